// File: rtl/music_sequencer.sv
// music_sequencer: plays a song from a 32-entry writable RAM, feeding length/pitch to the note timer.
// Latency: start -> first valid length 3 cycles; note_change -> next valid length 3 cycles.
// Backpressure: none; the timer paces playback through note_change, and stop aborts at once.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start/stop        begin playback from address 0 (IDLE only) / abort in any state
//   loop_en           restart at address 0 instead of finishing when the song ends
//   wr_en/addr/data   song RAM write port, entry = {length[3:0], pitch}
//   note_change       timer pulse: the current note has expired
//   length, pitch     current note to the timer and tone generator (0 between notes)
//   playing, done     playback active / one-cycle end-of-song pulse (non-looping end only)
//   cur_addr          address of the current song entry
module music_sequencer #(
   parameter int ADDR_W  = 5,
   parameter int PITCH_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  loop_en,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [4+PITCH_W-1:0]  wr_data,
   input  logic                  note_change,
   output logic [3:0]            length,
   output logic [PITCH_W-1:0]    pitch,
   output logic                  playing,
   output logic                  done,
   output logic [ADDR_W-1:0]     cur_addr
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int WORD_W = 4 + PITCH_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_CHECK = 2'd2,
      S_PLAY  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [3:0]          length_q, length_d;
   logic [PITCH_W-1:0]  pitch_q, pitch_d;
   logic                done_d;

   logic [WORD_W-1:0]   mem [DEPTH];
   logic [WORD_W-1:0]   rd_q;
   logic [3:0]          rd_len;
   logic [PITCH_W-1:0]  rd_pitch;
   logic                rd_valid;
   logic                last_addr;

   // Song RAM: not reset, so contents survive a mid-song reset. The read and
   // write in one cycle to the same address return the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (state_q == S_FETCH) begin
         rd_q <= mem[cur_addr_q];
      end
   end

   assign rd_len    = rd_q[WORD_W-1 -: 4];
   assign rd_pitch  = rd_q[PITCH_W-1:0];
   // Codes 1..7 are notes; 0 and 8..15 all mark the end of the song.
   assign rd_valid  = (rd_len != 4'd0) && !rd_len[3];
   assign last_addr = &cur_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cur_addr_q <= '0;
         length_q   <= 4'd0;
         pitch_q    <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         length_q   <= length_d;
         pitch_q    <= pitch_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      length_d   = length_q;
      pitch_d    = pitch_q;
      done_d     = 1'b0;

      if (stop) begin
         // Abort beats start and note_change; the address is kept for inspection.
         state_d  = S_IDLE;
         length_d = 4'd0;
         pitch_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               length_d = 4'd0;
               pitch_d  = '0;
               if (start) begin
                  cur_addr_d = '0;
                  state_d    = S_FETCH;
               end
            end
            S_FETCH: begin
               length_d = 4'd0;
               pitch_d  = '0;
               state_d  = S_CHECK;
            end
            S_CHECK: begin
               if (rd_valid) begin
                  length_d = rd_len;
                  pitch_d  = rd_pitch;
                  state_d  = S_PLAY;
               end else if (loop_en && (cur_addr_q != '0)) begin
                  cur_addr_d = '0;
                  state_d    = S_FETCH;
               end else begin
                  // Ending at address 0 means an empty song: looping would spin forever.
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_PLAY: begin
               if (note_change) begin
                  // Clearing length here produces the two-cycle gap in FETCH/CHECK.
                  length_d = 4'd0;
                  pitch_d  = '0;
                  if (!last_addr) begin
                     cur_addr_d = cur_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                     state_d    = S_FETCH;
                  end else if (loop_en) begin
                     cur_addr_d = '0;
                     state_d    = S_FETCH;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign length   = length_q;
   assign pitch    = pitch_q;
   assign playing  = (state_q != S_IDLE);
   assign done     = done_d;
   assign cur_addr = cur_addr_q;

endmodule

// File: tb/tb_music_sequencer.sv
module tb_music_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [9:0]  wr_data = '0;
   logic        note_change = 1'b0;
   logic [3:0]  length;
   logic [5:0]  pitch;
   logic        playing;
   logic        done;
   logic [4:0]  cur_addr;

   int n_cmp = 0;
   int n_bad = 0;

   music_sequencer #(.ADDR_W(5), .PITCH_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .note_change(note_change), .length(length), .pitch(pitch),
      .playing(playing), .done(done), .cur_addr(cur_addr)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 2ns after the edge.
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic write_entry(input logic [4:0] a, input logic [3:0] l, input logic [5:0] p);
      wr_en = 1'b1; wr_addr = a; wr_data = {l, p};
      tick;
      wr_en = 1'b0;
   endtask

   task automatic load_song;
      write_entry(5'd0, 4'd3, 6'd10);
      write_entry(5'd1, 4'd4, 6'd12);
      write_entry(5'd2, 4'd0, 6'd0);
   endtask

   task automatic pulse_note;
      note_change = 1'b1;
      tick;
      note_change = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      n_cmp++;
      if ({length, pitch, playing, done, cur_addr} !== 17'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got len=%0d pitch=%0d play=%0b done=%0b addr=%0d, want all 0",
                  length, pitch, playing, done, cur_addr);
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_basic_song;
      load_song();
      loop_en = 1'b0;
      start = 1'b1; tick; start = 1'b0;           // FETCH
      n_cmp++;
      if (playing !== 1'b1 || length !== 4'd0) begin
         n_bad++; $display("FAIL basic_fetch: play=%0b len=%0d, want 1/0", playing, length);
      end
      tick;                                       // CHECK
      n_cmp++;
      if (length !== 4'd0) begin
         n_bad++; $display("FAIL basic_check_gap: len=%0d, want 0", length);
      end
      tick;                                       // PLAY note 0
      n_cmp++;
      if (length !== 4'd3 || pitch !== 6'd10 || cur_addr !== 5'd0) begin
         n_bad++; $display("FAIL basic_note0: len=%0d pitch=%0d addr=%0d, want 3/10/0", length, pitch, cur_addr);
      end
      repeat (9) tick;
      pulse_note();                               // FETCH addr 1
      n_cmp++;
      if (length !== 4'd0) begin
         n_bad++; $display("FAIL basic_gap1: len=%0d, want 0", length);
      end
      tick;
      n_cmp++;
      if (length !== 4'd0) begin
         n_bad++; $display("FAIL basic_gap2: len=%0d, want 0", length);
      end
      tick;
      n_cmp++;
      if (length !== 4'd4 || pitch !== 6'd12 || cur_addr !== 5'd1) begin
         n_bad++; $display("FAIL basic_note1: len=%0d pitch=%0d addr=%0d, want 4/12/1", length, pitch, cur_addr);
      end
      repeat (9) tick;
      pulse_note();                               // FETCH addr 2
      tick;                                       // CHECK end marker
      n_cmp++;
      if (done !== 1'b1 || playing !== 1'b1) begin
         n_bad++; $display("FAIL basic_done_pulse: done=%0b play=%0b, want 1/1", done, playing);
      end
      tick;
      n_cmp++;
      if (done !== 1'b0 || playing !== 1'b0 || cur_addr !== 5'd2 || length !== 4'd0) begin
         n_bad++; $display("FAIL basic_end_idle: done=%0b play=%0b addr=%0d len=%0d, want 0/0/2/0",
                           done, playing, cur_addr, length);
      end
   endtask

   task automatic test_loop;
      logic saw_done;
      int   gap;
      logic [5:0] exp_p;
      int   exp_gap;
      saw_done = 1'b0;
      loop_en = 1'b1;
      start = 1'b1; tick; start = 1'b0;
      tick; tick;
      n_cmp++;
      if (pitch !== 6'd10) begin
         n_bad++; $display("FAIL loop_first: pitch=%0d, want 10", pitch);
      end
      for (int k = 0; k < 5; k++) begin
         exp_p   = (k % 2 == 0) ? 6'd12 : 6'd10;
         exp_gap = (k % 2 == 0) ? 3 : 5;          // wrap passes through an extra FETCH/CHECK
         pulse_note();
         gap = 1;
         while (length == 4'd0 && gap < 10) begin
            if (done) saw_done = 1'b1;
            tick;
            gap++;
         end
         n_cmp++;
         if (pitch !== exp_p || gap != exp_gap) begin
            n_bad++; $display("FAIL loop_note%0d: pitch=%0d gap=%0d, want %0d/%0d", k, pitch, gap, exp_p, exp_gap);
         end
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_bad++; $display("FAIL loop_no_done: saw done=%0b, want 0", saw_done);
      end
      stop = 1'b1; tick; stop = 1'b0;
      loop_en = 1'b0;
   endtask

   task automatic test_empty_song;
      write_entry(5'd0, 4'd0, 6'd7);
      loop_en = 1'b1;
      start = 1'b1; tick; start = 1'b0;
      tick;                                       // CHECK at addr 0
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++; $display("FAIL empty_done: done=%0b, want 1", done);
      end
      tick;
      n_cmp++;
      if (playing !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL empty_idle: play=%0b done=%0b, want 0/0", playing, done);
      end
      repeat (3) tick;
      n_cmp++;
      if (playing !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL empty_stays_idle: play=%0b done=%0b, want 0/0", playing, done);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_full_ram;
      for (int i = 0; i < 32; i++) write_entry(5'(i), 4'd2, 6'(i));
      loop_en = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      tick; tick;
      for (int i = 0; i < 32; i++) begin
         n_cmp++;
         if (cur_addr !== 5'(i) || length !== 4'd2 || pitch !== 6'(i)) begin
            n_bad++; $display("FAIL full_note%0d: addr=%0d len=%0d pitch=%0d, want %0d/2/%0d",
                              i, cur_addr, length, pitch, i, i);
         end
         note_change = 1'b1;
         #1;
         n_cmp++;
         if (done !== (i == 31)) begin
            n_bad++; $display("FAIL full_done%0d: done=%0b, want %0b", i, done, (i == 31));
         end
         tick;
         note_change = 1'b0;
         if (i < 31) begin
            tick; tick;
         end
      end
      n_cmp++;
      if (playing !== 1'b0 || cur_addr !== 5'd31) begin
         n_bad++; $display("FAIL full_end: play=%0b addr=%0d, want 0/31", playing, cur_addr);
      end
   endtask

   task automatic test_stop_priority;
      load_song();
      start = 1'b1; tick; start = 1'b0;
      tick; tick;
      pulse_note();
      tick; tick;                                 // PLAY addr 1
      n_cmp++;
      if (cur_addr !== 5'd1 || length !== 4'd4) begin
         n_bad++; $display("FAIL stop_setup: addr=%0d len=%0d, want 1/4", cur_addr, length);
      end
      stop = 1'b1; note_change = 1'b1; start = 1'b1;
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++; $display("FAIL stop_no_done: done=%0b, want 0", done);
      end
      tick;
      stop = 1'b0; note_change = 1'b0; start = 1'b0;
      n_cmp++;
      if (playing !== 1'b0 || length !== 4'd0 || pitch !== 6'd0 || cur_addr !== 5'd1) begin
         n_bad++; $display("FAIL stop_idle: play=%0b len=%0d pitch=%0d addr=%0d, want 0/0/0/1",
                           playing, length, pitch, cur_addr);
      end
      tick; tick;
      n_cmp++;
      if (playing !== 1'b0) begin
         n_bad++; $display("FAIL stop_stays_idle: play=%0b, want 0", playing);
      end
   endtask

   task automatic test_bad_code;
      write_entry(5'd1, 4'd9, 6'd5);
      loop_en = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      tick; tick;
      pulse_note();                               // FETCH addr 1
      n_cmp++;
      if (length !== 4'd0) begin
         n_bad++; $display("FAIL bad_fetch: len=%0d, want 0", length);
      end
      tick;                                       // CHECK sees code 9
      n_cmp++;
      if (done !== 1'b1 || length !== 4'd0) begin
         n_bad++; $display("FAIL bad_done: done=%0b len=%0d, want 1/0", done, length);
      end
      tick;
      n_cmp++;
      if (playing !== 1'b0 || length !== 4'd0 || cur_addr !== 5'd1) begin
         n_bad++; $display("FAIL bad_idle: play=%0b len=%0d addr=%0d, want 0/0/1", playing, length, cur_addr);
      end
   endtask

   task automatic test_reset_midplay;
      write_entry(5'd1, 4'd4, 6'd12);
      start = 1'b1; tick; start = 1'b0;
      tick; tick;
      pulse_note();
      tick; tick;                                 // PLAY addr 1
      repeat (3) tick;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({length, pitch, playing, done, cur_addr} !== 17'd0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got len=%0d pitch=%0d play=%0b done=%0b addr=%0d, want all 0",
                  length, pitch, playing, done, cur_addr);
      end
      tick;
      rst = 1'b0;
      tick;
      start = 1'b1; tick; start = 1'b0;
      tick; tick;
      n_cmp++;
      if (length !== 4'd3 || pitch !== 6'd10) begin
         n_bad++; $display("FAIL replay_note0: len=%0d pitch=%0d, want 3/10", length, pitch);
      end
      pulse_note();
      tick; tick;
      n_cmp++;
      if (length !== 4'd4 || pitch !== 6'd12 || cur_addr !== 5'd1) begin
         n_bad++; $display("FAIL replay_note1: len=%0d pitch=%0d addr=%0d, want 4/12/1", length, pitch, cur_addr);
      end
      stop = 1'b1; tick; stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_song();
      test_loop();
      test_empty_song();
      test_full_ram();
      test_stop_priority();
      test_bad_code();
      test_reset_midplay();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
